// File: rtl/aes128_round_sched.sv
// Iterative AES-128 encryption sequencer: one round per cycle, round keys expanded on the fly.
// Optional AES_ROUND_TRACE_EN adds a simulation-only per-round trace; logic and ports are unchanged.
module aes128_round_sched #(
  parameter int NR = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [0:127] in_state,
  input  logic [0:127] in_key,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [0:127] out_state,
  output logic         busy,
  output logic [3:0]   round_idx
);

  if (NR != 10) begin : g_nr_chk
    $error("aes128_round_sched: NR must be 10");
  end

  typedef enum logic [1:0] {S_IDLE, S_ROUND, S_FINAL, S_DONE} fsm_e;

  fsm_e         fsm_q;
  logic [127:0] data_q;
  logic [127:0] key_q;
  logic [7:0]   rcon_q;
  logic [3:0]   cnt_q;
  logic         in_ready_q, out_valid_q, busy_q;
  logic [3:0]   round_idx_q;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p, aa;
    p  = 8'h00;
    aa = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ aa;
      aa = xtime(aa);
    end
    return p;
  endfunction

  // Multiplicative inverse as x^254 (0 maps to 0), then the FIPS affine transform.
  function automatic logic [7:0] sbox(input logic [7:0] x);
    logic [7:0] sq, r;
    sq = x;
    r  = 8'h01;
    for (int i = 1; i < 8; i++) begin
      sq = gf_mul(sq, sq);
      r  = gf_mul(r, sq);
    end
    return r ^ {r[6:0], r[7]} ^ {r[5:0], r[7:6]} ^ {r[4:0], r[7:5]} ^
           {r[3:0], r[7:4]} ^ 8'h63;
  endfunction

  // Byte k of a block sits at [127-8k -: 8]; byte k is row k%4, column k/4.
  function automatic logic [127:0] sub_bytes(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int k = 0; k < 16; k++) o[127-8*k -: 8] = sbox(s[127-8*k -: 8]);
    return o;
  endfunction

  function automatic logic [127:0] shift_rows(input logic [127:0] s);
    logic [127:0] o;
    o = '0;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        o[127-8*(r+4*c) -: 8] = s[127-8*(r+4*((c+r)%4)) -: 8];
    return o;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] o;
    logic [7:0]   a0, a1, a2, a3;
    o = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c    -: 8];
      a1 = s[127-32*c-8  -: 8];
      a2 = s[127-32*c-16 -: 8];
      a3 = s[127-32*c-24 -: 8];
      o[127-32*c -: 32] = {
        xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3,
        a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3,
        a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3,
        xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3)};
    end
    return o;
  endfunction

  // Key step
  logic [31:0]  w0, w1, w2, w3, rot_w3, sub_t, nw0, nw1, nw2, nw3;
  logic [127:0] next_key_d;

  assign w0     = key_q[127:96];
  assign w1     = key_q[95:64];
  assign w2     = key_q[63:32];
  assign w3     = key_q[31:0];
  assign rot_w3 = {w3[23:0], w3[31:24]};
  assign sub_t  = {sbox(rot_w3[31:24]), sbox(rot_w3[23:16]),
                   sbox(rot_w3[15:8]),  sbox(rot_w3[7:0])};
  assign nw0    = w0 ^ sub_t ^ {rcon_q, 24'h0};
  assign nw1    = w1 ^ nw0;
  assign nw2    = w2 ^ nw1;
  assign nw3    = w3 ^ nw2;
  assign next_key_d = {nw0, nw1, nw2, nw3};

  // Round datapath; the final round skips MixColumns.
  logic [127:0] sr_state, round_out, final_out;

  assign sr_state  = shift_rows(sub_bytes(data_q));
  assign round_out = mix_columns(sr_state) ^ next_key_d;
  assign final_out = sr_state ^ next_key_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fsm_q       <= S_IDLE;
      data_q      <= '0;
      key_q       <= '0;
      rcon_q      <= 8'h01;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      round_idx_q <= '0;
    end else begin
      case (fsm_q)
        S_IDLE: if (in_valid && in_ready_q) begin
          data_q      <= in_state ^ in_key;
          key_q       <= in_key;
          rcon_q      <= 8'h01;
          cnt_q       <= 4'd1;
          fsm_q       <= S_ROUND;
          in_ready_q  <= 1'b0;
          busy_q      <= 1'b1;
          round_idx_q <= 4'd1;
        end
        S_ROUND: begin
          data_q <= round_out;
          key_q  <= next_key_d;
          rcon_q <= xtime(rcon_q);
          cnt_q  <= cnt_q + 4'd1;
          if (cnt_q == 4'(NR - 1)) begin
            fsm_q       <= S_FINAL;
            round_idx_q <= 4'(NR);
          end else begin
            round_idx_q <= cnt_q + 4'd1;
          end
        end
        S_FINAL: begin
          data_q      <= final_out;
          fsm_q       <= S_DONE;
          out_valid_q <= 1'b1;
          busy_q      <= 1'b0;
        end
        S_DONE: if (out_ready) begin
          fsm_q       <= S_IDLE;
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          round_idx_q <= '0;
        end
        default: fsm_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign round_idx = round_idx_q;
  assign out_state = data_q;

`ifdef AES_ROUND_TRACE_EN
  always @(posedge clk) begin
    if (rst_n && (fsm_q == S_ROUND || fsm_q == S_FINAL))
      $display("aes_trace round=%0d state=%h key=%h new=%h", round_idx_q, data_q,
               next_key_d, (fsm_q == S_FINAL) ? final_out : round_out);
  end
`endif

endmodule

// File: tb/tb_aes128_round_sched.sv
// Bench for aes128_round_sched: FIPS vectors, random blocks against a byte-array AES model,
// backpressure, back-to-back spacing, mid-block reset and ignored input.
module tb_aes128_round_sched;

  logic         clk = 1'b0;
  logic         rst_n, in_valid, in_ready, out_valid, out_ready, busy;
  logic [127:0] in_state, in_key, out_state;
  logic [3:0]   round_idx;

  int total = 0;
  int bad   = 0;
  logic [7:0] sbox_t [256];
  int idx_log [64];

  localparam logic [127:0] C1K = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] C1P = 128'h00112233445566778899aabbccddeeff;
  localparam logic [127:0] C1C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
  localparam logic [127:0] BK  = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] BP  = 128'h3243f6a8885a308d313198a2e0370734;
  localparam logic [127:0] BC  = 128'h3925841d02dc09fbdc118597196a0b32;

  aes128_round_sched #(.NR(10)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_state(in_state), .in_key(in_key), .out_valid(out_valid),
    .out_ready(out_ready), .out_state(out_state), .busy(busy), .round_idx(round_idx));

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] m2(input logic [7:0] b);
    return (b << 1) ^ ((b & 8'h80) != 0 ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [7:0] rol8(input logic [7:0] b, input int n);
    return (b << n) | (b >> (8 - n));
  endfunction

  // Walks the multiplicative group with generator 3 and its inverse in lockstep.
  task automatic build_sbox();
    logic [7:0] p, q;
    p = 8'h01;
    q = 8'h01;
    do begin
      p = p ^ m2(p);
      q = q ^ (q << 1);
      q = q ^ (q << 2);
      q = q ^ (q << 4);
      if (q[7]) q = q ^ 8'h09;
      sbox_t[p] = q ^ rol8(q, 1) ^ rol8(q, 2) ^ rol8(q, 3) ^ rol8(q, 4) ^ 8'h63;
    end while (p != 8'h01);
    sbox_t[0] = 8'h63;
  endtask

  function automatic logic [127:0] aes_ref(input logic [127:0] pt, input logic [127:0] key);
    logic [31:0]  w [44];
    logic [7:0]   st [16];
    logic [7:0]   tmp [16];
    logic [31:0]  t;
    logic [7:0]   rc, a0, a1, a2, a3;
    logic [127:0] res;
    rc = 8'h01;
    for (int i = 0; i < 4; i++) w[i] = key[127-32*i -: 32];
    for (int i = 4; i < 44; i++) begin
      t = w[i-1];
      if (i % 4 == 0) begin
        t = {t[23:0], t[31:24]};
        t = {sbox_t[t[31:24]], sbox_t[t[23:16]], sbox_t[t[15:8]], sbox_t[t[7:0]]};
        t = t ^ {rc, 24'h0};
        rc = m2(rc);
      end
      w[i] = w[i-4] ^ t;
    end
    for (int k = 0; k < 16; k++) st[k] = pt[127-8*k -: 8];
    for (int rnd = 0; rnd <= 10; rnd++) begin
      if (rnd > 0) begin
        for (int k = 0; k < 16; k++) tmp[k] = sbox_t[st[k]];
        for (int c = 0; c < 4; c++)
          for (int r = 0; r < 4; r++) st[r+4*c] = tmp[r+4*((c+r)%4)];
        if (rnd < 10)
          for (int c = 0; c < 4; c++) begin
            a0 = st[4*c]; a1 = st[4*c+1]; a2 = st[4*c+2]; a3 = st[4*c+3];
            st[4*c]   = m2(a0) ^ m2(a1) ^ a1 ^ a2 ^ a3;
            st[4*c+1] = a0 ^ m2(a1) ^ m2(a2) ^ a2 ^ a3;
            st[4*c+2] = a0 ^ a1 ^ m2(a2) ^ m2(a3) ^ a3;
            st[4*c+3] = m2(a0) ^ a0 ^ a1 ^ a2 ^ m2(a3);
          end
      end
      for (int c = 0; c < 4; c++)
        for (int r = 0; r < 4; r++) st[4*c+r] = st[4*c+r] ^ w[4*rnd+c][31-8*r -: 8];
    end
    res = '0;
    for (int k = 0; k < 16; k++) res[127-8*k -: 8] = st[k];
    return res;
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Called at a negedge; returns just after the accept edge.
  task automatic send(input logic [127:0] pt, input logic [127:0] key, output bit ok);
    in_state = pt;
    in_key   = key;
    in_valid = 1'b1;
    ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      if (in_ready) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    @(posedge clk);
  endtask

  // lat = number of negedges after the accept edge until out_valid is seen.
  task automatic wait_out(output logic [127:0] ct, output int lat);
    lat = 0;
    ct  = '0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      idx_log[lat] = int'(round_idx);
      lat++;
      if (out_valid) begin ct = out_state; break; end
    end
  endtask

  task automatic release_out();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    bit           ok;
    int           lat;
    logic [127:0] ct, pa, ka, exp;
    int           acc_cyc [$];
    logic [127:0] outs [$];

    build_sbox();
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; in_state = '0; in_key = '0;
    #12;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_round_idx", round_idx, 0);
    chk("rst_out_state", out_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // FIPS-197 C.1 with latency
    send(C1P, C1K, ok);
    chk("c1_accept", ok, 1);
    wait_out(ct, lat);
    chk("c1_latency", lat, 11);
    chk("c1_ct", ct, C1C);
    chk("c1_ct_model", ct, aes_ref(C1P, C1K));
    chk("c1_busy_done", busy, 0);
    release_out();
    chk("c1_idle_ready", in_ready, 1);
    chk("c1_idle_valid", out_valid, 0);

    // FIPS-197 App. B with round_idx stepping
    send(BP, BK, ok);
    chk("b_accept", ok, 1);
    wait_out(ct, lat);
    chk("b_ct", ct, BC);
    for (int k = 0; k < 10; k++) chk($sformatf("b_round_idx_%0d", k), idx_log[k], k + 1);
    chk("b_round_idx_done", idx_log[10], 10);
    release_out();

    // Backpressure in DONE
    pa = rnd128(); ka = rnd128(); exp = aes_ref(pa, ka);
    send(pa, ka, ok);
    wait_out(ct, lat);
    chk("bp_ct", ct, exp);
    in_state = rnd128(); in_key = rnd128(); in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_valid", out_valid, 1);
      chk("bp_state", out_state, exp);
      chk("bp_in_ready", in_ready, 0);
    end
    in_valid = 1'b0;
    release_out();
    chk("bp_after_busy", busy, 0);
    chk("bp_after_ready", in_ready, 1);
    chk("bp_after_valid", out_valid, 0);

    // Back-to-back with in_valid held high
    pa = rnd128(); ka = rnd128();
    in_state = C1P; in_key = C1K; in_valid = 1'b1; out_ready = 1'b1;
    for (int cyc = 0; cyc < 40; cyc++) begin
      if (acc_cyc.size() == 1) begin in_state = pa; in_key = ka; end
      if (acc_cyc.size() == 2) in_valid = 1'b0;
      if (in_valid && in_ready) acc_cyc.push_back(cyc);
      if (out_valid) outs.push_back(out_state);
      @(negedge clk);
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("b2b_accepts", acc_cyc.size(), 2);
    chk("b2b_spacing", (acc_cyc.size() >= 2) ? acc_cyc[1] - acc_cyc[0] : -1, 12);
    chk("b2b_outs", outs.size(), 2);
    chk("b2b_ct0", (outs.size() >= 1) ? outs[0] : '0, C1C);
    chk("b2b_ct1", (outs.size() >= 2) ? outs[1] : '0, aes_ref(pa, ka));

    // Reset at round 5
    send(C1P, C1K, ok);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (round_idx == 4'd5) break;
    end
    chk("mid_at_round5", round_idx, 5);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_ready", in_ready, 1);
    chk("mid_rst_idx", round_idx, 0);
    chk("mid_rst_state", out_state, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    send(C1P, C1K, ok);
    chk("mid_re_accept", ok, 1);
    wait_out(ct, lat);
    chk("mid_re_ct", ct, C1C);
    release_out();

    // in_valid pulse with a different key while busy
    pa = rnd128(); ka = rnd128(); exp = aes_ref(pa, ka);
    send(pa, ka, ok);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    in_state = rnd128(); in_key = ~ka; in_valid = 1'b1;
    chk("ign_in_ready", in_ready, 0);
    wait_out(ct, lat);
    chk("ign_ct", ct, exp);
    release_out();

    // Random blocks with random consumer delay
    for (int n = 0; n < 4; n++) begin
      pa = rnd128(); ka = rnd128(); exp = aes_ref(pa, ka);
      send(pa, ka, ok);
      chk("rnd_accept", ok, 1);
      wait_out(ct, lat);
      chk($sformatf("rnd_ct_%0d", n), ct, exp);
      chk($sformatf("rnd_lat_%0d", n), lat, 11);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      chk($sformatf("rnd_hold_%0d", n), out_state, exp);
      release_out();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
